// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM with registered reads, A-wins write collision and a hardware clear FSM.
// Optional macro DPRAM_PARITY_EN adds a stored even-parity bit per word and parity error flags.
module dpram_param #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              clr,
    output logic              busy,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_in_a,
    input  logic              we_a,
    input  logic              re_a,
    output logic [DATA_W-1:0] data_out_a,
    output logic              valid_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_in_b,
    input  logic              we_b,
    input  logic              re_b,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_b,
    output logic              collision,
    output logic              parity_err_a,
    output logic              parity_err_b,
    input  logic              perr_inj
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef DPRAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic              busy_d;
    logic              clear_we;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  clear_word, wdata_a, wdata_b, word_a, word_b;
    logic              act, wr_a, wr_b, rd_a, rd_b, coll_hit, perr_a, perr_b;

    // Word encoding: with parity, bit DATA_W holds even parity so a good word XORs to 0
`ifdef DPRAM_PARITY_EN
    assign clear_word = {^INIT_VAL, INIT_VAL};
    assign wdata_a    = {(^data_in_a) ^ perr_inj, data_in_a};
    assign wdata_b    = {^data_in_b, data_in_b};
    assign perr_a     = ^word_a;
    assign perr_b     = ^word_b;
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj;
    assign clear_word = INIT_VAL;
    assign wdata_a    = data_in_a;
    assign wdata_b    = data_in_b;
    assign perr_a     = 1'b0;
    assign perr_b     = 1'b0;
`endif

    assign word_a   = mem[addr_a];
    assign word_b   = mem[addr_b];
    assign act      = (state == ST_IDLE) && cs;
    assign wr_a     = act && we_a;
    assign wr_b     = act && we_b;
    assign rd_a     = act && re_a && !we_a;
    assign rd_b     = act && re_b && !we_b;
    assign coll_hit = wr_a && wr_b && (addr_a == addr_b);

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
        end
    end

    // Clear FSM next state: sweep every address once, then serve ports
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        busy_d   = busy;
        clear_we = 1'b0;
        case (state)
            ST_INIT: begin
                clear_we = 1'b1;
                cnt_d    = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Array writes; on a same-address collision port A wins
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt] <= clear_word;
        end else begin
            if (wr_b && !coll_hit) mem[addr_b] <= wdata_b;
            if (wr_a)              mem[addr_a] <= wdata_a;
        end
    end

    // Registered read ports (read-first against the opposite port's write)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_a   <= '0;
            data_out_b   <= '0;
            valid_a      <= 1'b0;
            valid_b      <= 1'b0;
            parity_err_a <= 1'b0;
            parity_err_b <= 1'b0;
            collision    <= 1'b0;
        end else begin
            valid_a      <= rd_a;
            valid_b      <= rd_b;
            parity_err_a <= rd_a && perr_a;
            parity_err_b <= rd_b && perr_b;
            collision    <= coll_hit;
            if (rd_a) data_out_a <= word_a[DATA_W-1:0];
            if (rd_b) data_out_b <= word_b[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_dpram_param.sv
// Directed bench for dpram_param: clear timing, reads/writes, collision, read-first, soft clear, parity.
// Honours DPRAM_PARITY_EN to pick the expected parity flag.
module tb_dpram_param;
`ifdef DPRAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cs, clr, busy;
    logic [5:0] addr_a, addr_b;
    logic [7:0] data_in_a, data_in_b, data_out_a, data_out_b;
    logic       we_a, re_a, valid_a, we_b, re_b, valid_b;
    logic       collision, parity_err_a, parity_err_b, perr_inj;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dpram_param dut (
        .clk(clk), .rst(rst), .cs(cs), .clr(clr), .busy(busy),
        .addr_a(addr_a), .data_in_a(data_in_a), .we_a(we_a), .re_a(re_a),
        .data_out_a(data_out_a), .valid_a(valid_a),
        .addr_b(addr_b), .data_in_b(data_in_b), .we_b(we_b), .re_b(re_b),
        .data_out_b(data_out_b), .valid_b(valid_b),
        .collision(collision), .parity_err_a(parity_err_a),
        .parity_err_b(parity_err_b), .perr_inj(perr_inj)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we_a = 0; re_a = 0; we_b = 0; re_b = 0; clr = 0; perr_inj = 0;
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 0; i < 63; i++) tick();
        check({tag, "_busy63"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_busy64"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 0; cs = 1; addr_a = 0; addr_b = 0; data_in_a = 0; data_in_b = 0;
        quiet();
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_dout_a", 32'(data_out_a), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_perr_a", 32'(parity_err_a), 32'd0);

        rst = 1;
        re_a = 1; addr_a = 6'd1;
        tick();
        check("init_read_ignored", 32'(valid_a), 32'd0);
        quiet();
        for (int i = 0; i < 62; i++) tick();
        check("init_busy63", 32'(busy), 32'd1);
        tick();
        check("init_busy64", 32'(busy), 32'd0);

        re_a = 1; addr_a = 6'd5; re_b = 1; addr_b = 6'd10;
        tick();
        check("rd0_a", 32'(data_out_a), 32'h00);
        check("rd0_valid_a", 32'(valid_a), 32'd1);
        check("rd0_b", 32'(data_out_b), 32'h00);
        check("rd0_valid_b", 32'(valid_b), 32'd1);
        quiet();

        we_a = 1; addr_a = 6'd5; data_in_a = 8'hAA;
        tick();
        check("wr_valid_a", 32'(valid_a), 32'd0);
        quiet(); re_a = 1;
        tick();
        check("rdAA", 32'(data_out_a), 32'hAA);
        check("rdAA_valid", 32'(valid_a), 32'd1);
        quiet();
        tick();
        check("valid_pulse", 32'(valid_a), 32'd0);
        check("dout_hold", 32'(data_out_a), 32'hAA);

        we_b = 1; addr_b = 6'd10; data_in_b = 8'h55;
        tick();
        quiet(); re_b = 1;
        tick();
        check("rd55", 32'(data_out_b), 32'h55);
        quiet();

        we_a = 1; we_b = 1; addr_a = 6'd5; addr_b = 6'd5; data_in_a = 8'hBB; data_in_b = 8'hCC;
        tick();
        check("coll_pulse", 32'(collision), 32'd1);
        quiet();
        re_a = 1; re_b = 1;
        tick();
        check("coll_clear", 32'(collision), 32'd0);
        check("coll_rd_a", 32'(data_out_a), 32'hBB);
        check("coll_rd_b", 32'(data_out_b), 32'hBB);
        quiet();

        we_a = 1; addr_a = 6'd15; data_in_a = 8'hDD; re_b = 1; addr_b = 6'd15;
        tick();
        check("rfirst_old", 32'(data_out_b), 32'h00);
        check("rfirst_valid", 32'(valid_b), 32'd1);
        check("rfirst_nocoll", 32'(collision), 32'd0);
        quiet(); re_b = 1;
        tick();
        check("rfirst_new", 32'(data_out_b), 32'hDD);
        quiet();

        we_a = 1; re_a = 1; addr_a = 6'd16; data_in_a = 8'h77;
        tick();
        check("we_re_valid", 32'(valid_a), 32'd0);
        check("we_re_hold", 32'(data_out_a), 32'hBB);
        quiet(); re_a = 1;
        tick();
        check("we_re_stored", 32'(data_out_a), 32'h77);

        cs = 0; addr_a = 6'd5;
        tick();
        check("cs0_valid", 32'(valid_a), 32'd0);
        check("cs0_hold", 32'(data_out_a), 32'h77);
        cs = 1; quiet();

        we_a = 1; addr_a = 6'd30; data_in_a = 8'h31; we_b = 1; addr_b = 6'd31; data_in_b = 8'h32;
        tick();
        check("diff_nocoll", 32'(collision), 32'd0);
        quiet(); re_a = 1; re_b = 1;
        tick();
        check("diff_a", 32'(data_out_a), 32'h31);
        check("diff_b", 32'(data_out_b), 32'h32);
        quiet();

        we_a = 1; addr_a = 6'd20; data_in_a = 8'h12;
        tick();
        quiet(); clr = 1;
        tick();
        check("clr_busy", 32'(busy), 32'd1);
        quiet(); re_a = 1; addr_a = 6'd20;
        tick();
        check("clr_read_ignored", 32'(valid_a), 32'd0);
        quiet();
        for (int i = 0; i < 62; i++) tick();
        check("clr_busy63", 32'(busy), 32'd1);
        tick();
        check("clr_busy64", 32'(busy), 32'd0);
        re_a = 1; addr_a = 6'd20; re_b = 1; addr_b = 6'd5;
        tick();
        check("clr_rd20", 32'(data_out_a), 32'h00);
        check("clr_rd5", 32'(data_out_b), 32'h00);
        quiet();

        we_a = 1; addr_a = 6'd40; data_in_a = 8'h44;
        tick();
        quiet(); clr = 1;
        tick();
        quiet();
        for (int i = 0; i < 30; i++) tick();
        rst = 0;
        #1;
        check("midrst_busy", 32'(busy), 32'd1);
        tick();
        rst = 1;
        wait_clear("midrst");
        re_a = 1; addr_a = 6'd40;
        tick();
        check("midrst_rd40", 32'(data_out_a), 32'h00);
        quiet();

        we_a = 1; perr_inj = 1; addr_a = 6'd3; data_in_a = 8'h0F;
        tick();
        quiet(); we_a = 1; addr_a = 6'd4; data_in_a = 8'h0F;
        tick();
        quiet(); re_a = 1; addr_a = 6'd3; re_b = 1; addr_b = 6'd3;
        tick();
        check("par_inj_data", 32'(data_out_a), 32'h0F);
        check("par_inj_a", 32'(parity_err_a), 32'(PAR));
        check("par_inj_b", 32'(parity_err_b), 32'(PAR));
        quiet(); re_a = 1; addr_a = 6'd4;
        tick();
        check("par_clean_a", 32'(parity_err_a), 32'd0);
        check("par_clean_data", 32'(data_out_a), 32'h0F);
        quiet();
        tick();
        check("par_pulse", 32'(parity_err_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
